// File: rtl/spi_access_sequencer_pkg.sv
// Shared definitions for the SPI access sequencer: spi_controller register map,
// CONTROL/STATUS bit fields and the sequencer state encoding.
package spi_access_sequencer_pkg;

    localparam logic [1:0] SPI_ADDR_CONTROL = 2'd0;
    localparam logic [1:0] SPI_ADDR_STATUS  = 2'd1;
    localparam logic [1:0] SPI_ADDR_TXDATA  = 2'd2;
    localparam logic [1:0] SPI_ADDR_RXDATA  = 2'd3;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CPOL_BIT  = 1;
    localparam int CTRL_CPHA_BIT  = 2;
    localparam int CTRL_LEN_LSB   = 3;
    localparam int CTRL_LEN_W     = 8;
    localparam int CTRL_DIV_LSB   = 11;
    localparam int CTRL_DIV_W     = 8;

    localparam int STATUS_READY_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_TX   = 4'd1,
        ST_WR_CTRL = 4'd2,
        ST_WAIT    = 4'd3,
        ST_RD_STAT = 4'd4,
        ST_CHK     = 4'd5,
        ST_RD_RX   = 4'd6,
        ST_CAP     = 4'd7,
        ST_DONE    = 4'd8
    } seq_state_e;

endpackage

// File: rtl/spi_access_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1, wrapping modulo NUM_REQ, so the last winner has lowest priority.
module spi_access_sequencer_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int c;
        any = 1'b0;
        idx = '0;
        c   = 0;
        // Walk from farthest to nearest so the nearest set bit wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (req[IDX_W'(c)]) begin
                any = 1'b1;
                idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/spi_access_sequencer.sv
// Shares one spi_controller between NUM_REQ clients: round-robin grant, then a
// full TX-write / start / poll / RX-read job on the Avalon-MM master port.
module spi_access_sequencer
    import spi_access_sequencer_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   avmm_clk,
    input  logic                   avmm_reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*32-1:0]  req_cfg,
    input  logic [NUM_REQ*32-1:0]  req_txdata,
    output logic [NUM_REQ-1:0]     ack,
    output logic [31:0]            rsp_rxdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   m_cs,
    output logic [1:0]             m_addr,
    output logic                   m_write,
    output logic [31:0]            m_writedata,
    output logic                   m_read,
    input  logic [31:0]            m_readdata
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [31:0]       cfg_q, cfg_d;
    logic [31:0]       tx_q, tx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [31:0]       rx_q, rx_d;
    logic              err_q, err_d;

    logic              arb_any;
    logic [IDX_W-1:0]  arb_idx;
    logic [31:0]       cfg_sel;
    logic [31:0]       tx_sel;

    spi_access_sequencer_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .any (arb_any),
        .idx (arb_idx)
    );

    always_comb begin
        cfg_sel = '0;
        tx_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                cfg_sel = req_cfg[32*i +: 32];
                tx_sel  = req_txdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        cfg_d       = cfg_q;
        tx_d        = tx_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        err_d       = err_q;
        m_cs        = 1'b0;
        m_addr      = '0;
        m_write     = 1'b0;
        m_writedata = '0;
        m_read      = 1'b0;
        ack         = '0;

        // One counter serves both the settle wait and the ready timeout.
        if ((state_q inside {ST_WAIT, ST_RD_STAT, ST_CHK}) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_idx_d = arb_idx;
                    ptr_d       = arb_idx;
                    cfg_d       = cfg_sel;
                    tx_d        = tx_sel;
                    err_d       = 1'b0;
                    state_d     = ST_WR_TX;
                end
            end
            ST_WR_TX: begin
                m_cs        = 1'b1;
                m_addr      = SPI_ADDR_TXDATA;
                m_write     = 1'b1;
                m_writedata = tx_q;
                state_d     = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                m_cs        = 1'b1;
                m_addr      = SPI_ADDR_CONTROL;
                m_write     = 1'b1;
                m_writedata = cfg_q | (32'd1 << CTRL_START_BIT);
                cnt_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q >= SETTLE_LAST) begin
                    state_d = ST_RD_STAT;
                end
            end
            ST_RD_STAT: begin
                m_cs    = 1'b1;
                m_addr  = SPI_ADDR_STATUS;
                m_read  = 1'b1;
                state_d = ST_CHK;
            end
            ST_CHK: begin
                if (m_readdata[STATUS_READY_BIT]) begin
                    state_d = ST_RD_RX;
                end else if (cnt_q >= TIMEOUT_LIM) begin
                    err_d   = 1'b1;
                    rx_d    = '0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD_STAT;
                end
            end
            ST_RD_RX: begin
                m_cs    = 1'b1;
                m_addr  = SPI_ADDR_RXDATA;
                m_read  = 1'b1;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                rx_d    = m_readdata;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ack[grant_idx_q] = 1'b1;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge avmm_clk or negedge avmm_reset_n) begin
        if (!avmm_reset_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            cfg_q       <= '0;
            tx_q        <= '0;
            cnt_q       <= '0;
            rx_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            cfg_q       <= cfg_d;
            tx_q        <= tx_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            err_q       <= err_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign rsp_err    = (state_q == ST_DONE) && err_q;
    assign rsp_rxdata = rx_q;
    assign grant_idx  = grant_idx_q;

endmodule

// File: tb/tb_spi_access_sequencer.sv
// Bench for spi_access_sequencer with a behavioural spi_controller slave
// (MISO looped to MOSI) and a scoreboard of expected {err, idx, rxdata} per ack.
`timescale 1ns/1ps
module tb_spi_access_sequencer;
    import spi_access_sequencer_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int SETTLE  = 4;
    localparam int TMO     = 64;
    localparam int SB_W    = 1 + IDX_W + 32;
    localparam logic [31:0] CFG =
        ((32'd13 & 32'((1 << CTRL_DIV_W) - 1)) << CTRL_DIV_LSB) |
        (32'd16 << CTRL_LEN_LSB) | (32'd0 << CTRL_CPOL_BIT) | (32'd0 << CTRL_CPHA_BIT);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ*32-1:0] req_cfg = {NUM_REQ{CFG}};
    logic [NUM_REQ*32-1:0] req_txdata = '0;
    logic [NUM_REQ-1:0]    ack;
    logic [31:0]           rsp_rxdata;
    logic                  rsp_err;
    logic                  busy;
    logic [IDX_W-1:0]      grant_idx;
    logic                  m_cs;
    logic [1:0]            m_addr;
    logic                  m_write;
    logic [31:0]           m_writedata;
    logic                  m_read;
    logic [31:0]           m_readdata = '0;

    spi_access_sequencer #(
        .NUM_REQ        (NUM_REQ),
        .IDX_W          (IDX_W),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .avmm_clk     (clk),
        .avmm_reset_n (rst_n),
        .req          (req),
        .req_cfg      (req_cfg),
        .req_txdata   (req_txdata),
        .ack          (ack),
        .rsp_rxdata   (rsp_rxdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .m_cs         (m_cs),
        .m_addr       (m_addr),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_read       (m_read),
        .m_readdata   (m_readdata)
    );

    // ---------------- slave model ----------------
    logic [31:0] s_tx = '0, s_ctrl = '0, s_rx = '0;
    logic        s_busy = 1'b0;
    logic        s_stuck = 1'b0;
    int          s_remain = 0;
    int          s_fix_delay = -1;

    function automatic logic [31:0] len_mask(input logic [31:0] ctrl);
        int len;
        len = int'(ctrl[CTRL_LEN_LSB +: CTRL_LEN_W]);
        if (len >= 32) return '1;
        return (32'd1 << len) - 32'd1;
    endfunction

    always @(posedge clk) begin
        if (m_cs && m_write) begin
            case (m_addr)
                SPI_ADDR_TXDATA: s_tx <= m_writedata;
                SPI_ADDR_CONTROL: begin
                    s_ctrl <= m_writedata;
                    if (m_writedata[CTRL_START_BIT]) begin
                        s_busy   <= 1'b1;
                        s_remain <= (s_fix_delay >= 0) ? s_fix_delay : int'($urandom_range(3, 40));
                    end
                end
                default: ;
            endcase
        end else if (s_busy && !s_stuck) begin
            if (s_remain == 0) begin
                s_busy <= 1'b0;
                s_rx   <= s_tx & len_mask(s_ctrl);
            end else begin
                s_remain <= s_remain - 1;
            end
        end
        if (m_cs && m_read) begin
            case (m_addr)
                SPI_ADDR_STATUS: m_readdata <= {31'd0, ~s_busy};
                SPI_ADDR_RXDATA: m_readdata <= s_rx;
                SPI_ADDR_TXDATA: m_readdata <= s_tx;
                default:         m_readdata <= s_ctrl;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [SB_W-1:0] exp_q[$];
    logic [SB_W-1:0] sb_exp, sb_got;
    int model_ptr = NUM_REQ - 1;
    logic [31:0] tx_words [NUM_REQ];

    always @(negedge clk) begin
        if (rst_n && ack != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack=%b with empty expected queue", ack);
            end else begin
                sb_exp = exp_q.pop_front();
                sb_got = {rsp_err, grant_idx, rsp_rxdata};
                if (sb_got !== sb_exp || ack !== (NUM_REQ'(1) << sb_exp[32 +: IDX_W])) begin
                    errors++;
                    $display("FAIL scoreboard: ack=%b {err,idx,rx}=%h expected idx %0d {err,idx,rx}=%h",
                             ack, sb_got, sb_exp[32 +: IDX_W], sb_exp);
                end
            end
        end
        if (m_cs) begin
            checks++;
            if (m_read && m_write) begin
                errors++;
                $display("FAIL rw_exclusive: m_read=%b m_write=%b, required not both", m_read, m_write);
            end
        end
        if (m_cs && m_write && m_addr == SPI_ADDR_TXDATA) begin
            checks++;
            if (s_busy) begin
                errors++;
                $display("FAIL tx_while_busy: TX write while slave ready=0");
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_tx(input int i, input logic [31:0] v);
        tx_words[i] = v;
        req_txdata[32*i +: 32] = v;
    endtask

    // Predict the grant order of a round and queue the expected responses.
    task automatic push_round(input logic [NUM_REQ-1:0] mask, input int njobs, input bit rearm);
        logic [NUM_REQ-1:0] pend;
        int c;
        bit found;
        pend = mask;
        for (int j = 0; j < njobs; j++) begin
            found = 1'b0;
            c = 0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!found && pend[(model_ptr + k) % NUM_REQ]) begin
                    found = 1'b1;
                    c = (model_ptr + k) % NUM_REQ;
                end
            end
            if (found) begin
                exp_q.push_back({1'b0, IDX_W'(c), tx_words[c] & 32'h0000_FFFF});
                model_ptr = c;
                if (!rearm) pend[c] = 1'b0;
            end
        end
    endtask

    // Holds req=mask; each acked client drops req for the following idle cycle.
    task automatic run_round(input logic [NUM_REQ-1:0] mask, input int njobs, input bit rearm,
                             input string name);
        int got_jobs;
        int cyc;
        logic [NUM_REQ-1:0] back;
        got_jobs = 0;
        cyc = 0;
        req = mask;
        while (got_jobs < njobs && cyc < 400 * njobs) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                got_jobs++;
                req = req & ~ack;
                if (got_jobs >= njobs) begin
                    req = '0;
                end else if (rearm) begin
                    back = ack;
                    @(negedge clk);
                    @(negedge clk);
                    cyc += 2;
                    req = req | back;
                end
            end
        end
        req = '0;
        checks++;
        if (got_jobs != njobs) begin
            errors++;
            $display("FAIL %s_jobs: got %0d acks, required %0d", name, got_jobs, njobs);
        end
    endtask

    task automatic wait_slave_idle();
        int n;
        n = 0;
        while (s_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ack, busy, rsp_err, rsp_rxdata, grant_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b busy=%b err=%b rx=%h idx=%0d, required all 0",
                     ack, busy, rsp_err, rsp_rxdata, grant_idx);
        end
        checks++;
        if ({m_cs, m_read, m_write, m_addr, m_writedata} !== '0) begin
            errors++;
            $display("FAIL reset_master: cs=%b rd=%b wr=%b addr=%0d wdata=%h, required all 0",
                     m_cs, m_read, m_write, m_addr, m_writedata);
        end
    endtask

    task automatic test_single();
        int n;
        set_tx(1, 32'h0000_A5C3);
        s_fix_delay = 0;
        push_round(4'b0010, 1, 1'b0);
        req = 4'b0010;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b1 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL single_grant: busy=%b idx=%0d, required 1 and 1", busy, grant_idx);
        end
        checks++;
        if ({m_cs, m_write, m_read, m_addr, m_writedata} !== {3'b110, SPI_ADDR_TXDATA, 32'h0000_A5C3}) begin
            errors++;
            $display("FAIL single_wr_tx: cs=%b wr=%b rd=%b addr=%0d wdata=%h, required 1 1 0 2 0000a5c3",
                     m_cs, m_write, m_read, m_addr, m_writedata);
        end
        @(negedge clk);
        checks++;
        if ({m_cs, m_write, m_read, m_addr, m_writedata} !== {3'b110, SPI_ADDR_CONTROL, CFG | 32'd1}) begin
            errors++;
            $display("FAIL single_wr_ctrl: cs=%b wr=%b rd=%b addr=%0d wdata=%h, required 1 1 0 0 %h",
                     m_cs, m_write, m_read, m_addr, m_writedata, CFG | 32'd1);
        end
        n = 2;
        while (ack == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req = '0;
        checks++;
        if (n !== 7 + SETTLE) begin
            errors++;
            $display("FAIL single_latency: grant-to-ack %0d cycles, required %0d", n, 7 + SETTLE);
        end
        @(negedge clk);
        checks++;
        if (ack !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after_done: ack=%b busy=%b, required 0 0", ack, busy);
        end
        s_fix_delay = -1;
    endtask

    task automatic test_contention();
        for (int i = 0; i < NUM_REQ; i++) set_tx(i, 32'($urandom));
        push_round(4'b1111, 8, 1'b1);
        run_round(4'b1111, 8, 1'b1, "contention");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] mask;
        for (int r = 0; r < 4; r++) begin
            mask = NUM_REQ'($urandom_range(1, 15));
            for (int i = 0; i < NUM_REQ; i++) set_tx(i, 32'($urandom));
            push_round(mask, $countones(mask), 1'b0);
            run_round(mask, $countones(mask), 1'b0, "back_to_back");
        end
        @(negedge clk);
    endtask

    task automatic test_latch();
        int n;
        set_tx(0, 32'h0000_1234);
        push_round(4'b0001, 1, 1'b0);
        req = 4'b0001;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_txdata[31:0] = 32'h0000_FFFF;
        #1;
        checks++;
        if (m_writedata !== 32'h0000_1234) begin
            errors++;
            $display("FAIL latch_tx_write: wdata=%h, required 00001234", m_writedata);
        end
        n = 0;
        while (ack == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req = '0;
        checks++;
        if (ack == '0) begin
            errors++;
            $display("FAIL latch_ack: no ack within 200 cycles, required one");
        end
        set_tx(0, 32'h0000_1234);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        s_stuck = 1'b1;
        set_tx(2, 32'h0000_5A5A);
        exp_q.push_back({1'b1, 2'd2, 32'h0});
        model_ptr = 2;
        req = 4'b0100;
        n = 0;
        while (!(m_write && m_addr == SPI_ADDR_CONTROL) && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (ack == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req = '0;
        checks++;
        if (n < TMO || n > TMO + SETTLE + 3) begin
            errors++;
            $display("FAIL timeout_window: start-to-ack %0d cycles, required %0d..%0d",
                     n, TMO, TMO + SETTLE + 3);
        end
        s_stuck = 1'b0;
        wait_slave_idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        int n;
        set_tx(3, 32'($urandom));
        req = 4'b1000;
        n = 0;
        while (!(m_write && m_addr == SPI_ADDR_CONTROL) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, busy, rsp_err, rsp_rxdata, grant_idx, m_cs, m_read, m_write, m_addr, m_writedata} !== '0) begin
            errors++;
            $display("FAIL reset_async: ack=%b busy=%b err=%b rx=%h idx=%0d cs=%b addr=%0d, required all 0",
                     ack, busy, rsp_err, rsp_rxdata, grant_idx, m_cs, m_addr);
        end
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = NUM_REQ - 1;
        wait_slave_idle();
        @(negedge clk);
        push_round(4'b1000, 1, 1'b0);
        run_round(4'b1000, 1, 1'b0, "rerun_after_reset");
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) tx_words[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_latch();
        test_timeout();
        test_reset_mid_job();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: %0d responses never acked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
